status_irq_sequencer: RTL and testbench

- Converts the 14-bit sticky status word from the status monitor into one MCU interrupt line (IRQ).
- Sequences the write-1-to-clear (W1C) handshake back to the status monitor: queues MCU clear requests, issues single-cycle `status_clr_pulse`/`status_clr_mask`, then re-evaluates pending status after a settle holdoff.
- Sits between the register bank (SPI side) and the status monitor, in the HF_CLK domain.

---
 rtl/status_irq_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_status_irq_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/status_irq_sequencer.sv
// rtl/status_irq_sequencer.sv - sticky status word to MCU IRQ with W1C clear sequencing
// Optional build macro STATUS_IRQ_COALESCE_EN adds an IDLE coalescing window (COALESCE_CYC).
module status_irq_sequencer #(
  parameter int STATUS_W    = 14,
  parameter int PULSE_W_CYC = 16,
  parameter int HOLDOFF_CYC = 4,
  parameter int CNT_W       = 8
`ifdef STATUS_IRQ_COALESCE_EN
  , parameter int COALESCE_CYC = 32
`endif
) (
  input  logic                HF_CLK,
  input  logic                RST_sync,
  input  logic [STATUS_W-1:0] status,
  input  logic [STATUS_W-1:0] irq_en_mask,
  input  logic                irq_mode,
  input  logic                clr_req,
  input  logic [STATUS_W-1:0] clr_data,
  output logic                status_clr_pulse,
  output logic [STATUS_W-1:0] status_clr_mask,
  output logic                irq,
  output logic [STATUS_W-1:0] irq_src,
  output logic                busy
);

  // Bit 13 (ENSAMP) is a level indicator and is stripped from events and clears.
  localparam logic [STATUS_W-1:0] EVT_MASK    = ~(STATUS_W'(1) << 13);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_PULSE   = CNT_W'(PULSE_W_CYC);
  localparam logic [CNT_W-1:0]    CNT_HOLDOFF = CNT_W'(HOLDOFF_CYC);
`ifdef STATUS_IRQ_COALESCE_EN
  // FIFO overflow/underflow must not wait for the coalescing window.
  localparam logic [STATUS_W-1:0] BYPASS_MASK = (STATUS_W'(1) << 9) | (STATUS_W'(1) << 10);
  localparam logic [CNT_W-1:0]    CNT_WINDOW  = CNT_W'(COALESCE_CYC);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ASSERT   = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_HOLDOFF  = 3'd3
`ifdef STATUS_IRQ_COALESCE_EN
    , S_WINDOW = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STATUS_W-1:0] clr_q, clr_d;
  logic [STATUS_W-1:0] pend_prev_q;
  logic                mode_q, mode_d;
  logic                irq_q, irq_d;
  logic [STATUS_W-1:0] irq_src_q, irq_src_d;
  logic                clr_pulse_q, clr_pulse_d;
  logic [STATUS_W-1:0] clr_mask_q, clr_mask_d;
  logic                busy_q, busy_d;

  logic [STATUS_W-1:0] pending;
  logic [STATUS_W-1:0] rise;
  logic                new_evt;
  logic                issue;
  logic                take;

  // Clear queue, event detection and next-state/output decode.
  always_comb begin
    pending = status & irq_en_mask & EVT_MASK;
    rise    = pending & ~pend_prev_q;
    new_evt = |rise;
    // Pulses are spaced by at least one idle cycle so the monitor sees distinct strobes.
    issue   = (clr_q != '0) && !clr_pulse_q;
    clr_d   = (issue ? '0 : clr_q) | (clr_req ? (clr_data & EVT_MASK) : '0);

    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    irq_src_d = irq_src_q;
    take      = 1'b0;

    if (issue) begin
      // A clear always restarts the settle holdoff, whatever the FSM was doing.
      state_d = S_HOLDOFF;
      cnt_d   = CNT_HOLDOFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (new_evt || (!irq_mode && (|pending))) begin
`ifdef STATUS_IRQ_COALESCE_EN
            if (|(rise & BYPASS_MASK)) begin
              take = 1'b1;
            end else begin
              state_d = S_WINDOW;
              cnt_d   = CNT_WINDOW;
            end
`else
            take = 1'b1;
`endif
          end
        end
        S_ASSERT: begin
          // Level mode holds here until a clear pulse arrives.
          if (mode_q) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else begin
              state_d = S_WAIT_ACK;
              cnt_d   = '0;
            end
          end
        end
        S_WAIT_ACK: begin
          state_d = S_WAIT_ACK;
        end
        S_HOLDOFF: begin
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (|pending) begin
            take = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
`ifdef STATUS_IRQ_COALESCE_EN
        S_WINDOW: begin
          if (|(rise & BYPASS_MASK)) begin
            take = 1'b1;
          end else if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (|pending) begin
            take = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Entering ASSERT snapshots the pending bits and latches the IRQ mode.
    if (take) begin
      state_d   = S_ASSERT;
      cnt_d     = CNT_PULSE;
      mode_d    = irq_mode;
      irq_src_d = pending;
    end

    irq_d       = (state_d == S_ASSERT);
    clr_pulse_d = issue;
    clr_mask_d  = issue ? clr_q : '0;
    busy_d      = (clr_d != '0) || (state_d == S_HOLDOFF);
  end

  // State, queue and registered outputs with synchronous reset.
  always_ff @(posedge HF_CLK) begin
    if (RST_sync) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      clr_q       <= '0;
      pend_prev_q <= '0;
      mode_q      <= 1'b0;
      irq_q       <= 1'b0;
      irq_src_q   <= '0;
      clr_pulse_q <= 1'b0;
      clr_mask_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
      pend_prev_q <= pending;
      mode_q      <= mode_d;
      irq_q       <= irq_d;
      irq_src_q   <= irq_src_d;
      clr_pulse_q <= clr_pulse_d;
      clr_mask_q  <= clr_mask_d;
      busy_q      <= busy_d;
    end
  end

  assign status_clr_pulse = clr_pulse_q;
  assign status_clr_mask  = clr_mask_q;
  assign irq              = irq_q;
  assign irq_src          = irq_src_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_status_irq_sequencer.sv
// tb/tb_status_irq_sequencer.sv - scoreboard bench for status_irq_sequencer
module tb_status_irq_sequencer;

  localparam int SW = 14;
  localparam int PW = 16;
  localparam int HC = 4;
`ifdef STATUS_IRQ_COALESCE_EN
  localparam int CC = 32;
  localparam logic [SW-1:0] BYP = 14'h0600;
`endif

  logic          HF_CLK = 1'b0;
  logic          RST_sync;
  logic [SW-1:0] status, irq_en_mask, clr_data;
  logic          irq_mode, clr_req;
  logic          status_clr_pulse, irq, busy;
  logic [SW-1:0] status_clr_mask, irq_src;

  status_irq_sequencer #(
    .STATUS_W(SW), .PULSE_W_CYC(PW), .HOLDOFF_CYC(HC), .CNT_W(8)
  ) dut (
    .HF_CLK(HF_CLK), .RST_sync(RST_sync), .status(status), .irq_en_mask(irq_en_mask),
    .irq_mode(irq_mode), .clr_req(clr_req), .clr_data(clr_data),
    .status_clr_pulse(status_clr_pulse), .status_clr_mask(status_clr_mask),
    .irq(irq), .irq_src(irq_src), .busy(busy)
  );

  always #5 HF_CLK = ~HF_CLK;

  typedef struct packed {
    logic          irq;
    logic [SW-1:0] src;
    logic          pulse;
    logic [SW-1:0] mask;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: remaining-cycle counters and flags derived from the rules.
  logic [SW-1:0] m_prev, m_queue, m_src, m_mask;
  bit m_pulse, m_irq, m_busy, m_plsmode, m_wait;
  int m_left, m_hold, m_win;

  logic [SW-1:0] cur_st, cur_en;
  bit cur_md;

  task automatic m_raise(input logic [SW-1:0] pend, input bit md);
    m_irq = 1; m_src = pend; m_plsmode = md; m_left = PW;
  endtask

  task automatic model(input bit rst, input logic [SW-1:0] st, input logic [SW-1:0] en,
                       input bit md, input bit cr, input logic [SW-1:0] cd);
    logic [SW-1:0] pend, rise, qn;
    bit fire;
    if (rst) begin
      m_prev = 0; m_queue = 0; m_src = 0; m_mask = 0;
      m_pulse = 0; m_irq = 0; m_busy = 0; m_plsmode = 0; m_wait = 0;
      m_left = 0; m_hold = 0; m_win = 0;
    end else begin
      pend = st & en & 14'h1FFF;
      rise = pend & ~m_prev;
      fire = (m_queue != 0) && !m_pulse;
      qn = fire ? 14'h0 : m_queue;
      if (cr) qn = qn | (cd & 14'h1FFF);
      m_mask = fire ? m_queue : 14'h0;
      m_pulse = fire;
      m_queue = qn;
      if (fire) begin
        m_irq = 0; m_wait = 0; m_win = 0; m_hold = HC;
      end else if (m_hold > 0) begin
        if (m_hold == 1) begin
          m_hold = 0;
          if (pend != 0) m_raise(pend, md);
        end else m_hold--;
      end else if (m_irq) begin
        if (m_plsmode) begin
          m_left--;
          if (m_left == 0) begin m_irq = 0; m_wait = 1; end
        end
      end else if (m_wait) begin
        m_wait = 1;
`ifdef STATUS_IRQ_COALESCE_EN
      end else if (m_win > 0) begin
        if ((rise & BYP) != 0) begin m_win = 0; m_raise(pend, md); end
        else if (m_win == 1) begin m_win = 0; if (pend != 0) m_raise(pend, md); end
        else m_win--;
      end else if (rise != 0 || (!md && pend != 0)) begin
        if ((rise & BYP) != 0) m_raise(pend, md);
        else m_win = CC;
      end
`else
      end else if (rise != 0 || (!md && pend != 0)) begin
        m_raise(pend, md);
      end
`endif
      m_prev = pend;
      m_busy = (m_queue != 0) || (m_hold > 0);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then advance.
  task automatic apply(input bit rst, input logic [SW-1:0] st, input logic [SW-1:0] en,
                       input bit md, input bit cr, input logic [SW-1:0] cd);
    exp_t e;
    RST_sync = rst; status = st; irq_en_mask = en; irq_mode = md;
    clr_req = cr; clr_data = cd;
    model(rst, st, en, md, cr, cd);
    e.irq = m_irq; e.src = m_src; e.pulse = m_pulse; e.mask = m_mask; e.busy = m_busy;
    exp_q.push_back(e);
    @(posedge HF_CLK);
    #2;
  endtask

  task automatic tick(input bit cr, input logic [SW-1:0] cd);
    apply(1'b0, cur_st, cur_en, cur_md, cr, cd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 14'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, cur_st, cur_en, cur_md, 1'b0, 14'h0);
  endtask

  task automatic cmp(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: pops one expected entry per presented output cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge HF_CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("irq", {13'h0, irq}, {13'h0, e.irq});
        cmp("irq_src", irq_src, e.src);
        cmp("clr_pulse", {13'h0, status_clr_pulse}, {13'h0, e.pulse});
        cmp("clr_mask", status_clr_mask, e.mask);
        cmp("busy", {13'h0, busy}, {13'h0, e.busy});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog @%0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cur_st = 0; cur_en = 14'h3FFF; cur_md = 1;
    #1;
    do_reset(3);

    // Pulse mode: bit 9 rises, IRQ high for PW cycles, then cleared.
    idle(7);
    cur_st = 14'h0200; idle(25);
    tick(1'b1, 14'h0200); cur_st = 0; idle(8);

    // Level mode: held bit, W1C clear, status drops during holdoff.
    do_reset(1); cur_md = 0; cur_st = 14'h0100; idle(5);
    tick(1'b1, 14'h0100); idle(1); cur_st = 0; idle(8);

    // Re-raise during holdoff.
    cur_st = 14'h0001; idle(3);
    tick(1'b1, 14'h0001); cur_st = 0; idle(1); cur_st = 14'h0001; idle(8);

    // Back-to-back clears.
    tick(1'b1, 14'h0001); tick(1'b1, 14'h0002); idle(8);
    cur_st = 0; idle(6);

    // ENSAMP never interrupts or clears; reset during ASSERT.
    do_reset(1); cur_md = 0; cur_st = 14'h2000; idle(5);
    tick(1'b1, 14'h2000); idle(5);
    cur_st = 14'h0004; idle(3); do_reset(1); cur_st = 0; idle(3);

`ifdef STATUS_IRQ_COALESCE_EN
    // Coalescing window and FIFO bypass.
    do_reset(1); cur_md = 1; idle(2);
    cur_st = 14'h0001; idle(5); cur_st = 14'h0003; idle(40);
    tick(1'b1, 14'h0003); cur_st = 0; idle(8);
    cur_st = 14'h0004; idle(3); cur_st = 14'h0204; idle(20);
`endif

    // Randomized traffic.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      bit r, cr;
      logic [SW-1:0] cd;
      if ($urandom_range(0, 5) == 0) cur_st = cur_st ^ (14'h0001 << $urandom_range(0, 13));
      if ($urandom_range(0, 200) == 0) cur_en = 14'($urandom);
      if ($urandom_range(0, 100) == 0) cur_md = ~cur_md;
      cr = ($urandom_range(0, 9) < 2);
      cd = ($urandom_range(0, 1) == 1) ? cur_st : 14'($urandom);
      r = ($urandom_range(0, 400) == 0);
      if (cr && $urandom_range(0, 1) == 1) cur_st = cur_st & ~cd;
      apply(r, cur_st, cur_en, cur_md, cr, cd);
    end
    idle(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
